// File: rtl/idct_da_8pt.sv
// 8-point inverse DCT using MSB-first bit-serial distributed arithmetic.
// Eight Q10 accumulators are loaded over COEF_W cycles, then eight samples stream out under valid/ready.
module idct_da_8pt #(
    parameter int COEF_W = 8,
    localparam int ACC_W = COEF_W + 12,
    localparam int OUT_W = COEF_W + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] z0,
    input  logic signed [COEF_W-1:0] z1,
    input  logic signed [COEF_W-1:0] z2,
    input  logic signed [COEF_W-1:0] z3,
    input  logic signed [COEF_W-1:0] z4,
    input  logic signed [COEF_W-1:0] z5,
    input  logic signed [COEF_W-1:0] z6,
    input  logic signed [COEF_W-1:0] z7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [2:0]               out_idx,
    output logic [1:0]               fsm_state
);
    localparam int CNT_W = $clog2(COEF_W);
    localparam int ROM_W = 13;

    localparam logic signed [ROM_W-1:0] CA = 13'sd362;
    localparam logic signed [ROM_W-1:0] CB = 13'sd473;
    localparam logic signed [ROM_W-1:0] CC = 13'sd196;
    localparam logic signed [ROM_W-1:0] CD = 13'sd502;
    localparam logic signed [ROM_W-1:0] CE = 13'sd426;
    localparam logic signed [ROM_W-1:0] CF = 13'sd284;
    localparam logic signed [ROM_W-1:0] CG = 13'sd100;

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;

    state_t state, state_next;
    logic [COEF_W-1:0] zs [8];
    logic [CNT_W-1:0] cnt;
    logic signed [ACC_W-1:0] acc_e [4];
    logic signed [ACC_W-1:0] acc_o [4];
    logic signed [ROM_W-1:0] rom_e [4];
    logic signed [ROM_W-1:0] rom_o [4];
    logic [3:0] ebits, obits;
    logic last_bit;

    // Address bit 3 selects the first constant of the tuple (Z0 or Z1).
    function automatic logic signed [ROM_W-1:0] rom(input logic [3:0] bits,
                                                    input logic signed [ROM_W-1:0] k0,
                                                    input logic signed [ROM_W-1:0] k1,
                                                    input logic signed [ROM_W-1:0] k2,
                                                    input logic signed [ROM_W-1:0] k3);
        logic signed [ROM_W-1:0] s;
        s = '0;
        if (bits[3]) s = s + k0;
        if (bits[2]) s = s + k1;
        if (bits[1]) s = s + k2;
        if (bits[0]) s = s + k3;
        return s;
    endfunction

    assign ebits = {zs[0][COEF_W-1], zs[2][COEF_W-1], zs[4][COEF_W-1], zs[6][COEF_W-1]};
    assign obits = {zs[1][COEF_W-1], zs[3][COEF_W-1], zs[5][COEF_W-1], zs[7][COEF_W-1]};

    always_comb begin
        rom_e[0] = rom(ebits, CA, CB, CA, CC);
        rom_e[1] = rom(ebits, CA, CC, -CA, -CB);
        rom_e[2] = rom(ebits, CA, -CC, -CA, CB);
        rom_e[3] = rom(ebits, CA, -CB, CA, -CC);
        rom_o[0] = rom(obits, CD, CE, CF, CG);
        rom_o[1] = rom(obits, CE, -CG, -CD, -CF);
        rom_o[2] = rom(obits, CF, -CD, CG, CE);
        rom_o[3] = rom(obits, CG, -CF, CE, -CD);
    end

    assign last_bit = (cnt == CNT_W'(COEF_W - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = ACC;
            ACC:  if (last_bit) state_next = OUT;
            OUT:  if (out_ready && out_idx == 3'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == OUT);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            out_idx <= '0;
            for (int i = 0; i < 8; i++) zs[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                acc_e[i] <= '0;
                acc_o[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) begin
                    zs[0] <= z0; zs[1] <= z1; zs[2] <= z2; zs[3] <= z3;
                    zs[4] <= z4; zs[5] <= z5; zs[6] <= z6; zs[7] <= z7;
                    cnt <= '0;
                    for (int i = 0; i < 4; i++) begin
                        acc_e[i] <= '0;
                        acc_o[i] <= '0;
                    end
                end
                ACC: begin
                    for (int i = 0; i < 8; i++) zs[i] <= {zs[i][COEF_W-2:0], 1'b0};
                    // The first (sign) bit carries negative weight in two's complement.
                    for (int i = 0; i < 4; i++) begin
                        if (cnt == '0) begin
                            acc_e[i] <= -{{(ACC_W-ROM_W){rom_e[i][ROM_W-1]}}, rom_e[i]};
                            acc_o[i] <= -{{(ACC_W-ROM_W){rom_o[i][ROM_W-1]}}, rom_o[i]};
                        end else begin
                            acc_e[i] <= (acc_e[i] <<< 1) + {{(ACC_W-ROM_W){rom_e[i][ROM_W-1]}}, rom_e[i]};
                            acc_o[i] <= (acc_o[i] <<< 1) + {{(ACC_W-ROM_W){rom_o[i][ROM_W-1]}}, rom_o[i]};
                        end
                    end
                    cnt <= cnt + 1'b1;
                    if (last_bit) out_idx <= '0;
                end
                OUT: if (out_ready) out_idx <= out_idx + 3'd1;
                default: ;
            endcase
        end
    end

    logic [1:0] pair;
    logic signed [ACC_W:0] e_sel, o_sel, full, rnd;
    logic unused_rnd;

    // Indices 4..7 mirror 3..0 with the odd half subtracted.
    always_comb begin
        pair  = out_idx[2] ? ~out_idx[1:0] : out_idx[1:0];
        e_sel = {acc_e[pair][ACC_W-1], acc_e[pair]};
        o_sel = {acc_o[pair][ACC_W-1], acc_o[pair]};
        full  = out_idx[2] ? (e_sel - o_sel) : (e_sel + o_sel);
        rnd   = full + (ACC_W+1)'(512);
    end

    assign out_data   = out_valid ? rnd[OUT_W+9:10] : '0;
    assign unused_rnd = ^{rnd[ACC_W:OUT_W+10], rnd[9:0]};
endmodule

// File: tb/tb_idct_da_8pt.sv
// Directed bench for idct_da_8pt: DC, odd, extreme, backpressure and reset-abort blocks.
module tb_idct_da_8pt;
    localparam int COEF_W = 8;
    localparam int OUT_W  = COEF_W + 2;

    logic clk = 0;
    logic reset, in_valid, in_ready, out_valid, out_ready;
    logic signed [COEF_W-1:0] zin [8];
    logic signed [OUT_W-1:0] out_data;
    logic [2:0] out_idx;
    logic [1:0] fsm_state;

    logic [OUT_W-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail = 0;

    idct_da_8pt #(.COEF_W(COEF_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .z0(zin[0]), .z1(zin[1]), .z2(zin[2]), .z3(zin[3]),
        .z4(zin[4]), .z5(zin[5]), .z6(zin[6]), .z7(zin[7]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_z(input int v0, v1, v2, v3, v4, v5, v6, v7);
        zin[0] = v0[COEF_W-1:0]; zin[1] = v1[COEF_W-1:0];
        zin[2] = v2[COEF_W-1:0]; zin[3] = v3[COEF_W-1:0];
        zin[4] = v4[COEF_W-1:0]; zin[5] = v5[COEF_W-1:0];
        zin[6] = v6[COEF_W-1:0]; zin[7] = v7[COEF_W-1:0];
    endtask

    task automatic push_exp(input int e0, e1, e2, e3, e4, e5, e6, e7);
        exp_q.push_back(e0[OUT_W-1:0]); exp_q.push_back(e1[OUT_W-1:0]);
        exp_q.push_back(e2[OUT_W-1:0]); exp_q.push_back(e3[OUT_W-1:0]);
        exp_q.push_back(e4[OUT_W-1:0]); exp_q.push_back(e5[OUT_W-1:0]);
        exp_q.push_back(e6[OUT_W-1:0]); exp_q.push_back(e7[OUT_W-1:0]);
    endtask

    // Handshake one block and wait (bounded) for the first out_valid.
    task automatic send_block(input string name);
        int lat;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready before send: got %b want 1", name, in_ready);
        end
        in_valid = 1;
        tick();
        in_valid = 0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat != COEF_W) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, COEF_W);
        end
    endtask

    // Drain samples from index `first` to 7 with out_ready held high.
    task automatic collect(input string name, input int first, input logic [7:0] mask);
        logic [OUT_W-1:0] e;
        out_ready = 1;
        for (int k = first; k < 8; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'(k)) begin
                n_fail++;
                $display("FAIL %s valid/idx k=%0d: got %b/%0d want 1/%0d", name, k, out_valid, out_idx, k);
            end
            if (mask[k]) begin
                n_checks++;
                if (out_data !== e) begin
                    n_fail++;
                    $display("FAIL %s x%0d: got %0d want %0d", name, k, out_data, $signed(e));
                end
            end
            tick();
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end of block: got in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 0; out_ready = 1;
        set_z(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== 3'd0 || fsm_state !== 2'd0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state: got v=%b d=%0d i=%0d s=%0d r=%b want 0/0/0/0/0",
                     out_valid, out_data, out_idx, fsm_state, in_ready);
        end
        reset = 0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset release in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_dc();
        set_z(64, 0, 0, 0, 0, 0, 0, 0);
        push_exp(23, 23, 23, 23, 23, 23, 23, 23);
        send_block("dc");
        collect("dc", 0, 8'hFF);
    endtask

    task automatic test_neg_dc();
        set_z(-128, 0, 0, 0, 0, 0, 0, 0);
        push_exp(-45, -45, -45, -45, -45, -45, -45, -45);
        send_block("neg_dc");
        collect("neg_dc", 0, 8'hFF);
    endtask

    task automatic test_odd();
        set_z(0, 100, 0, 0, 0, 0, 0, 0);
        push_exp(49, 42, 28, 10, -10, -28, -42, -49);
        send_block("odd");
        collect("odd", 0, 8'hFF);
    endtask

    task automatic test_extremes();
        set_z(127, 127, 127, 127, 127, 127, 127, 127);
        push_exp(335, -91, 73, -25, 39, -4, 23, 10);
        send_block("max");
        collect("max", 0, 8'hFF);
        set_z(-128, -128, -128, -128, -128, -128, -128, -128);
        push_exp(-338, 92, -73, 26, -39, 4, -23, -10);
        send_block("min");
        collect("min", 0, 8'hFF);
    endtask

    task automatic test_backpressure();
        set_z(0, 100, 0, 0, 0, 0, 0, 0);
        push_exp(49, 42, 28, 10, -10, -28, -42, -49);
        send_block("bp");
        out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            void'(exp_q.pop_front());
            tick();
        end
        out_ready = 0;
        set_z(64, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            in_valid = (c != 1);
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_data !== 10'sd28 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp hold c=%0d: got v=%b i=%0d d=%0d r=%b want 1/2/28/0",
                         c, out_valid, out_idx, out_data, in_ready);
            end
            tick();
        end
        in_valid = 0;
        set_z(0, 100, 0, 0, 0, 0, 0, 0);
        collect("bp", 2, 8'hFF);
    endtask

    task automatic test_reset_mid_acc();
        set_z(64, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1;
        tick();
        in_valid = 0;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (fsm_state !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_acc state before reset: got %0d want 1", fsm_state);
        end
        reset = 1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || fsm_state !== 2'd0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_acc abort: got v=%b s=%0d r=%b want 0/0/0", out_valid, fsm_state, in_ready);
        end
        reset = 0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_acc release in_ready: got %b want 1", in_ready);
        end
        set_z(0, 100, 0, 0, 0, 0, 0, 0);
        push_exp(49, 42, 28, 10, -10, -28, -42, -49);
        send_block("after_reset");
        collect("after_reset", 0, 8'hFF);
    endtask

    initial begin
        test_reset();
        test_dc();
        test_neg_dc();
        test_odd();
        test_extremes();
        test_backpressure();
        test_reset_mid_acc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
